// File: rtl/multi_timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer.
package multi_timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Prescaler counter width; at least one bit so PRESCALE=1 still has a legal register.
  function automatic int unsigned presc_width(input int unsigned presc);
    return (presc <= 1) ? 1 : $clog2(presc);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: reload/mode latch, expiry pulse and sticky status.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             g_reset,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] load_i,
  output logic             expired_o,
  output logic             busy_o,
  output logic             status_o,
  output logic [WIDTH-1:0] count_o
);

  chan_state_e      state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic             exp_q, exp_d;
  logic             sts_q, sts_d;

  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      cnt_q   <= '0;
      rel_q   <= '0;
      exp_q   <= 1'b0;
      sts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      exp_q   <= exp_d;
      sts_q   <= sts_d;
    end
  end

  // Priority: start (load/retrigger) > stop > tick-driven countdown.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    exp_d   = 1'b0;
    sts_d   = sts_q & ~clear_i;

    if (start_i) begin
      rel_d  = load_i;
      mode_d = periodic_i ? MODE_PERIODIC : MODE_ONESHOT;
      if (load_i != '0) begin
        state_d = ST_RUN;
        cnt_d   = load_i;
      end else begin
        // Zero load expires immediately and never enters RUN, even in periodic mode.
        state_d = ST_IDLE;
        cnt_d   = '0;
        exp_d   = 1'b1;
      end
    end else if (stop_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_RUN && tick_i) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        exp_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          cnt_d = rel_q;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end

    if (exp_d) begin
      sts_d = 1'b1;
    end
  end

  assign expired_o = exp_q;
  assign busy_o    = (state_q == ST_RUN);
  assign status_o  = sts_q;
  assign count_o   = cnt_q;

endmodule

// File: rtl/multi_timer.sv
// N-channel countdown timer bank sharing one free-running prescaled tick.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  g_reset,
  input  logic [N_CH*WIDTH-1:0] load_value,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       periodic,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       expired,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       status,
  output logic [N_CH*WIDTH-1:0] count,
  output logic                  irq
);

  localparam int unsigned PW = presc_width(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Free-running prescaler; never restarted by channel activity.
  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .g_reset    (g_reset),
      .tick_i     (tick),
      .start_i    (start[i]),
      .stop_i     (stop[i]),
      .periodic_i (periodic[i]),
      .clear_i    (clear[i]),
      .load_i     (load_value[i*WIDTH +: WIDTH]),
      .expired_o  (expired[i]),
      .busy_o     (busy[i]),
      .status_o   (status[i]),
      .count_o    (count[i*WIDTH +: WIDTH])
    );
  end

  assign irq = |status;

endmodule

// File: tb/tb_multi_timer.sv
// Directed checks of multi_timer at PRESCALE=1, PRESCALE=4 and WIDTH=16.
module tb_multi_timer;

  logic        clk;
  logic        g_reset;
  int          n_cmp;
  int          n_err;
  int          ecnt;
  logic        seen;
  logic        bad;

  logic [31:0] a_load, a_cnt;
  logic [3:0]  a_start, a_stop, a_per, a_clr, a_exp, a_busy, a_sts;
  logic        a_irq;

  logic [31:0] p_load, p_cnt;
  logic [3:0]  p_start, p_stop, p_per, p_clr, p_exp, p_busy, p_sts;
  logic        p_irq;

  logic [31:0] w_load, w_cnt;
  logic [1:0]  w_start, w_stop, w_per, w_clr, w_exp, w_busy, w_sts;
  logic        w_irq;

  multi_timer #(.N_CH(4), .WIDTH(8), .PRESCALE(1)) dut_a (
    .clk(clk), .g_reset(g_reset), .load_value(a_load), .start(a_start), .stop(a_stop),
    .periodic(a_per), .clear(a_clr), .expired(a_exp), .busy(a_busy), .status(a_sts),
    .count(a_cnt), .irq(a_irq));

  multi_timer #(.N_CH(4), .WIDTH(8), .PRESCALE(4)) dut_p (
    .clk(clk), .g_reset(g_reset), .load_value(p_load), .start(p_start), .stop(p_stop),
    .periodic(p_per), .clear(p_clr), .expired(p_exp), .busy(p_busy), .status(p_sts),
    .count(p_cnt), .irq(p_irq));

  multi_timer #(.N_CH(2), .WIDTH(16), .PRESCALE(1)) dut_w (
    .clk(clk), .g_reset(g_reset), .load_value(w_load), .start(w_start), .stop(w_stop),
    .periodic(w_per), .clear(w_clr), .expired(w_exp), .busy(w_busy), .status(w_sts),
    .count(w_cnt), .irq(w_irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the PRESCALE=4 tick fires on edges where ecnt becomes a multiple of 4.
  always @(posedge clk or negedge g_reset) begin
    if (!g_reset) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; seen = 1'b0; bad = 1'b0;
    a_load = '0; a_start = '0; a_stop = '0; a_per = '0; a_clr = '0;
    p_load = '0; p_start = '0; p_stop = '0; p_per = '0; p_clr = '0;
    w_load = '0; w_start = '0; w_stop = '0; w_per = '0; w_clr = '0;
    g_reset = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_count", a_cnt, 32'd0);
    chk("rst_status", 32'(a_sts), 32'd0);
    chk("rst_expired", 32'(a_exp), 32'd0);
    chk("rst_irq", 32'(a_irq), 32'd0);
    g_reset = 1'b1;

    // One-shot ch0, V=3
    a_load[7:0] = 8'd3; a_start[0] = 1'b1; step(); a_start = '0;
    chk("os_cnt3", 32'(a_cnt[7:0]), 32'd3);
    chk("os_busy", 32'(a_busy[0]), 32'd1);
    step(); chk("os_cnt2", 32'(a_cnt[7:0]), 32'd2);
    step(); chk("os_cnt1", 32'(a_cnt[7:0]), 32'd1);
    chk("os_noexp", 32'(a_exp[0]), 32'd0);
    step();
    chk("os_exp", 32'(a_exp[0]), 32'd1);
    chk("os_idle", 32'(a_busy[0]), 32'd0);
    chk("os_cnt0", 32'(a_cnt[7:0]), 32'd0);
    chk("os_status", 32'(a_sts[0]), 32'd1);
    chk("os_irq", 32'(a_irq), 32'd1);
    step(); chk("os_pulse_end", 32'(a_exp[0]), 32'd0);
    a_clr[0] = 1'b1; step(); a_clr = '0;
    chk("clr_status", 32'(a_sts[0]), 32'd0);
    chk("clr_irq", 32'(a_irq), 32'd0);

    // Periodic ch1, V=5
    a_load[15:8] = 8'd5; a_per[1] = 1'b1; a_start[1] = 1'b1; step();
    a_start = '0; a_per = '0;
    for (int i = 1; i <= 22; i++) begin
      step();
      chk("per_exp", 32'(a_exp[1]), 32'((i % 5) == 0));
      chk("per_busy", 32'(a_busy[1]), 32'd1);
    end
    a_stop[1] = 1'b1; step(); a_stop = '0;
    chk("per_stop_busy", 32'(a_busy[1]), 32'd0);
    chk("per_stop_cnt", 32'(a_cnt[15:8]), 32'd0);
    seen = 1'b0;
    repeat (8) begin step(); seen = seen | a_exp[1]; end
    chk("per_stop_quiet", 32'(seen), 32'd0);
    a_clr[1] = 1'b1; step(); a_clr = '0;

    // Retrigger ch2: V=4 then V=6 two cycles later
    a_load[23:16] = 8'd4; a_start[2] = 1'b1; step(); a_start = '0;
    chk("rt_cnt4", 32'(a_cnt[23:16]), 32'd4);
    step(); step();
    chk("rt_cnt2", 32'(a_cnt[23:16]), 32'd2);
    a_load[23:16] = 8'd6; a_start[2] = 1'b1; step(); a_start = '0;
    chk("rt_cnt6", 32'(a_cnt[23:16]), 32'd6);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("rt_exp", 32'(a_exp[2]), 32'(i == 6));
    end
    // Zero load: immediate single pulse, never busy, even when periodic
    a_load[23:16] = 8'd0; a_per[2] = 1'b1; a_start[2] = 1'b1; step();
    a_start = '0; a_per = '0;
    chk("z_exp", 32'(a_exp[2]), 32'd1);
    chk("z_busy", 32'(a_busy[2]), 32'd0);
    chk("z_cnt", 32'(a_cnt[23:16]), 32'd0);
    step();
    chk("z_no_storm", 32'(a_exp[2]), 32'd0);
    chk("z_busy2", 32'(a_busy[2]), 32'd0);
    a_clr[2] = 1'b1; step(); a_clr = '0;

    // PRESCALE=4: start one edge after a tick edge
    for (int i = 0; i < 4 && (ecnt % 4) != 0; i++) step();
    p_load[31:24] = 8'd2; p_start[3] = 1'b1; step(); p_start = '0;
    chk("ps_cnt_load", 32'(p_cnt[31:24]), 32'd2);
    chk("ps_busy", 32'(p_busy[3]), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("ps_cnt", 32'(p_cnt[31:24]), 32'((i < 4) ? 2 : ((i < 8) ? 1 : 0)));
      chk("ps_exp", 32'(p_exp[3]), 32'(i == 8));
    end

    // start together with stop restarts
    a_load[7:0] = 8'd10; a_start[0] = 1'b1; step(); a_start = '0;
    step(); chk("ss_cnt9", 32'(a_cnt[7:0]), 32'd9);
    a_load[7:0] = 8'd4; a_start[0] = 1'b1; a_stop[0] = 1'b1; step();
    a_start = '0; a_stop = '0;
    chk("ss_busy", 32'(a_busy[0]), 32'd1);
    chk("ss_cnt4", 32'(a_cnt[7:0]), 32'd4);
    // stop on the expiry edge suppresses the pulse
    step(); step(); step();
    chk("se_cnt1", 32'(a_cnt[7:0]), 32'd1);
    a_stop[0] = 1'b1; step(); a_stop = '0;
    chk("se_noexp", 32'(a_exp[0]), 32'd0);
    chk("se_busy", 32'(a_busy[0]), 32'd0);
    chk("se_cnt", 32'(a_cnt[7:0]), 32'd0);
    chk("se_status", 32'(a_sts[0]), 32'd0);
    // start on the expiry edge reloads and drops the old expiry
    a_load[7:0] = 8'd2; a_start[0] = 1'b1; step(); a_start = '0;
    step();
    a_load[7:0] = 8'd3; a_start[0] = 1'b1; step(); a_start = '0;
    chk("sx_noexp", 32'(a_exp[0]), 32'd0);
    chk("sx_cnt3", 32'(a_cnt[7:0]), 32'd3);
    step(); step(); step();
    chk("sx_exp", 32'(a_exp[0]), 32'd1);
    a_clr[0] = 1'b1; step(); a_clr = '0;
    chk("sx_clr", 32'(a_sts[0]), 32'd0);
    // clear in the same cycle as the expiry set: set wins
    a_load[7:0] = 8'd2; a_start[0] = 1'b1; step(); a_start = '0;
    step();
    a_clr[0] = 1'b1; step(); a_clr = '0;
    chk("cs_exp", 32'(a_exp[0]), 32'd1);
    chk("cs_status", 32'(a_sts[0]), 32'd1);
    // equal loads on two channels expire together
    a_load[23:16] = 8'd3; a_load[31:24] = 8'd3; a_start[3:2] = 2'b11; step(); a_start = '0;
    step(); step();
    chk("sim_pre", 32'(a_exp), 32'd0);
    step();
    chk("sim_exp", 32'(a_exp), 32'hC);

    // Asynchronous reset mid-count
    a_load[7:0] = 8'd200; a_start[0] = 1'b1; step(); a_start = '0;
    repeat (80) step();
    chk("ar_cnt120", 32'(a_cnt[7:0]), 32'd120);
    #2 g_reset = 1'b0;
    #1;
    chk("ar_cnt", a_cnt, 32'd0);
    chk("ar_busy", 32'(a_busy), 32'd0);
    chk("ar_status", 32'(a_sts), 32'd0);
    chk("ar_exp", 32'(a_exp), 32'd0);
    chk("ar_irq", 32'(a_irq), 32'd0);
    step();
    g_reset = 1'b1;
    seen = 1'b0;
    repeat (210) begin step(); seen = seen | (|a_exp); end
    chk("ar_no_exp", 32'(seen), 32'd0);
    chk("ar_idle", 32'(a_busy), 32'd0);

    // WIDTH=16 full-range countdown
    w_load[15:0] = 16'hFFFF; w_start[0] = 1'b1; step(); w_start = '0;
    chk("w_load", 32'(w_cnt[15:0]), 32'hFFFF);
    bad = 1'b0;
    for (int i = 1; i <= 65534; i++) begin
      step();
      if (w_cnt[15:0] != 16'(65535 - i)) bad = 1'b1;
    end
    chk("w_track", 32'(bad), 32'd0);
    chk("w_cnt1", 32'(w_cnt[15:0]), 32'd1);
    chk("w_noexp", 32'(w_exp[0]), 32'd0);
    step();
    chk("w_exp", 32'(w_exp[0]), 32'd1);
    chk("w_cnt0", 32'(w_cnt[15:0]), 32'd0);
    chk("w_idle", 32'(w_busy[0]), 32'd0);
    step();
    chk("w_nowrap", 32'(w_cnt[15:0]), 32'd0);
    chk("w_pulse_end", 32'(w_exp[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised, multi-channel successor to the single 4-bit countdown timer.
- Provides N independent down-counting channels of configurable width, driven by a shared prescaled tick.
- Each channel supports one-shot or periodic mode, retrigger and stop, and keeps a sticky expiry status with per-channel clear.
- Sits beside the control FSMs as the timeout/periodic-event source; `irq` feeds the interrupt aggregator.

Parameters:
- N_CH, 4, number of independent timer channels (1..16)
- WIDTH, 8, load value and counter width in bits (2..32)
- PRESCALE, 1, clk cycles per count tick (1 = tick every cycle; max 2^16)

Ports:
- clk  in  1  system clock, all state on rising edge
- g_reset  in  1  asynchronous active-low reset
- load_value  in  N_CH*WIDTH  per-channel load value; channel i uses bits [i*WIDTH +: WIDTH]
- start  in  N_CH  per-channel start/retrigger strobe, sampled each clk
- stop  in  N_CH  per-channel stop strobe
- periodic  in  N_CH  mode, sampled with start: 1 = auto-reload, 0 = one-shot
- clear  in  N_CH  clears sticky status bit
- expired  out  N_CH  one-clk pulse per expiry
- busy  out  N_CH  channel is counting
- status  out  N_CH  sticky expiry flag
- count  out  N_CH*WIDTH  current counter value per channel
- irq  out  1  OR of status

Behaviour:
- Reset (g_reset=0, asynchronous):
  - expired, busy, status, count all 0; irq 0.
  - Latched reload values and modes cleared; prescaler counter cleared.
  - Reset mid-count aborts the channel silently, with no expired pulse.
- Prescaler:
  - Free-running counter 0..PRESCALE-1 from reset; tick=1 when counter == PRESCALE-1.
  - With PRESCALE=1, tick is constant 1.
  - Shared by all channels, never restarted by start.
- Channel states: IDLE (busy=0) and RUN (busy=1).
- start=1 at edge k, load value V:
  - V and mode are latched.
  - If V>0: count=V and busy=1 after edge k, regardless of prior state (retrigger reloads).
  - If V=0: count=0, busy stays 0, and expired pulses in the cycle after edge k. This is a one-shot even when periodic=1, so there is no pulse storm.
- RUN, on an edge with tick=1:
  - count>1: count decrements by 1.
  - count==1 (expiry edge): expired=1 for the following cycle only; status set.
    - One-shot: count=0 and busy=0.
    - Periodic: count reloads the latched V, busy stays 1.
- Without tick, count holds.
- Latency at PRESCALE=1: start at edge k gives expiry at edge k+V, i.e. exactly V cycles.
- stop=1:
  - Sets busy=0 and count=0 at the next edge; no expired pulse.
  - Stop coinciding with an expiry edge: stop wins, no pulse, status unchanged.
  - Stop while IDLE has no effect.
- start and stop in the same cycle: start wins (load/retrigger).
- start on the expiry edge: reload to the new V; the expiry of the old count is suppressed.
- status:
  - Set on any expired pulse; cleared by clear=1.
  - Set and clear in the same cycle: set wins.
- irq = |status, registered status driving combinational OR.
- Arithmetic: no underflow, since the decrement applies only when count>1. No wrap-around.
- Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.

Decomposition:
- Package multi_timer_pkg:
  - Mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
  - Channel state encoding ST_IDLE, ST_RUN.
  - Prescaler width function (clog2 of PRESCALE).
- Sub-module timer_channel (WIDTH param):
  - One counter, latched reload and mode, expired/busy/status logic.
  - Instantiated N_CH times by generate.
  - Top holds the prescaler, port slicing and the irq OR.

Test Plan:
1. N_CH=4, WIDTH=8, PRESCALE=1: release reset, start ch0 one-shot V=3 -> count 3,2,1 on successive cycles, expired[0] a single pulse 3 cycles after the start edge, busy[0] falls the same edge, status[0]=1, irq=1; clear[0] -> status 0, irq 0.
2. Periodic ch1 V=5 for 22 cycles -> expired[1] pulses at start+5, +10, +15, +20; busy stays 1; stop[1] -> busy 0, count 0, no further pulses.
3. Retrigger ch2 V=4, then start again with V=6 two cycles later -> single expiry at 6 cycles after the second start; start with V=0 -> expired pulse on the next cycle, busy never high.
4. PRESCALE=4: start ch3 V=2 aligned one cycle after a tick -> expiry on the second subsequent tick edge; check count holds between ticks.
5. Boundaries:
   - stop and start asserted together -> restart.
   - stop on the expiry edge -> no pulse.
   - clear on an expiry cycle -> status remains 1.
   - Two channels with equal V started together -> simultaneous pulses.
6. Assert g_reset low mid-count (ch0 V=200 at count 120) -> all outputs 0 immediately (asynchronously), no expired after release; WIDTH=16, V=16'hFFFF counts full range without wrap.
